// File: rtl/gui_pkg.sv
// Shared GUI definitions: pixel colours, the mode encodings and the
// renderer FSM state type.
package gui_pkg;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK = 3'b000;
  localparam colour_t BLUE  = 3'b001;
  localparam colour_t GREEN = 3'b010;
  localparam colour_t RED   = 3'b100;
  localparam colour_t WHITE = 3'b111;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_REC  = 2'b01,
    MODE_PLAY = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DRAW = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/key_display_renderer_if.sv
// Bus between a key/mode source and the renderer, plus the pixel-write
// stream and frame status coming back.
interface key_display_renderer_if #(
  parameter int NUM_KEYS = 4
);
  import gui_pkg::*;

  logic [NUM_KEYS-1:0] keys;
  logic                redraw_req;
  logic [1:0]          mode;
  logic [7:0]          x;
  logic [6:0]          y;
  colour_t             colour;
  logic                plot;
  logic                busy;
  logic                frame_done;

  modport master (
    output keys, redraw_req, mode,
    input  x, y, colour, plot, busy, frame_done
  );

  modport slave (
    input  keys, redraw_req, mode,
    output x, y, colour, plot, busy, frame_done
  );

endinterface

// File: rtl/pixel_scanner.sv
// Raster position counters. They point at the pixel that will be plotted
// next; key index and in-key offset run alongside x so no divide is needed.
// The counters wrap to the origin after the last pixel of the frame.
module pixel_scanner #(
  parameter int NUM_KEYS = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  output logic [7:0] x_cnt,
  output logic [6:0] y_cnt,
  output logic [2:0] key_idx,
  output logic [7:0] offset,
  output logic       last_pixel
);
  localparam int         KEY_W    = SCREEN_W / NUM_KEYS;
  localparam logic [7:0] X_LAST   = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST   = 7'(SCREEN_H - 1);
  localparam logic [7:0] OFF_LAST = 8'(KEY_W - 1);

  assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  // Step one pixel per advance, x fastest; start parks the scan at the origin.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      key_idx <= '0;
      offset  <= '0;
    end else if (advance) begin
      if (x_cnt == X_LAST) begin
        x_cnt   <= '0;
        key_idx <= '0;
        offset  <= '0;
        y_cnt   <= (y_cnt == Y_LAST) ? '0 : y_cnt + 7'd1;
      end else begin
        x_cnt <= x_cnt + 8'd1;
        if (offset == OFF_LAST) begin
          offset  <= '0;
          key_idx <= key_idx + 3'd1;
        end else begin
          offset <= offset + 8'd1;
        end
      end
    end else if (start) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      key_idx <= '0;
      offset  <= '0;
    end
  end

endmodule

// File: rtl/key_display_renderer.sv
// Draws a row of NUM_KEYS piano-style keys as a full-screen pixel stream.
// A frame starts on a redraw request, a change of the key levels against
// the last drawn snapshot, or right after reset release.
// Optional build macro MODE_INDICATOR_EN paints a 4x4 mode badge at the
// top-left corner (red while recording, green during playback).
//
// state | meaning
// IDLE  | waiting for a reason to draw; x/y hold the last pixel
// DRAW  | one pixel per cycle, plot high
// DONE  | single cycle, frame_done high
module key_display_renderer
  import gui_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic clock,
  input logic reset,
  key_display_renderer_if.slave bus
);
  localparam int         KEY_W    = SCREEN_W / NUM_KEYS;
  localparam logic [7:0] OFF_LAST = 8'(KEY_W - 1);
  localparam logic [2:0] KEY_LAST = 3'(NUM_KEYS - 1);

  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] snapshot;
  logic                req_pend;
  logic                first_frame;
  logic                plot_last;
  logic                go;
  logic                load;
  logic                scan_start;
  logic [7:0]          snap_src;
  colour_t             colour_d;
  logic [7:0]          sx;
  logic [6:0]          sy;
  logic [2:0]          skey;
  logic [7:0]          soff;
  logic                slast;

`ifdef MODE_INDICATOR_EN
  logic [1:0] mode_q;
  logic [1:0] mode_src;
`else
  logic unused_mode;
  assign unused_mode = ^bus.mode;
`endif

  pixel_scanner #(
    .NUM_KEYS (NUM_KEYS),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scanner (
    .clock      (clock),
    .reset      (reset),
    .start      (scan_start),
    .advance    (load),
    .x_cnt      (sx),
    .y_cnt      (sy),
    .key_idx    (skey),
    .offset     (soff),
    .last_pixel (slast)
  );

  assign go = (state_q == IDLE) &&
              (bus.redraw_req || req_pend || first_frame || (bus.keys != snapshot));

  assign bus.busy       = (state_q == DRAW);
  assign bus.frame_done = (state_q == DONE);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave DRAW once the last pixel is on the outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = DRAW;
      DRAW:    if (plot_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel load decision and colour of the pixel the scanner points at; on
  // the starting edge the live keys/mode are used since the snapshot is
  // being written on that same edge.
  always_comb begin
    load       = go || ((state_q == DRAW) && !plot_last);
    scan_start = !load && (state_q != DRAW);
    snap_src   = go ? 8'(bus.keys) : 8'(snapshot);
    if ((soff == OFF_LAST) && (skey < KEY_LAST)) colour_d = BLACK;
    else if (snap_src[skey])                     colour_d = BLUE;
    else                                         colour_d = WHITE;
`ifdef MODE_INDICATOR_EN
    mode_src = go ? bus.mode : mode_q;
    if ((sx < 8'd4) && (sy < 7'd4)) begin
      if (mode_src == MODE_REC)       colour_d = RED;
      else if (mode_src == MODE_PLAY) colour_d = GREEN;
    end
`endif
  end

  // Registered pixel outputs, frame snapshot and the pending-request flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.x       <= '0;
      bus.y       <= '0;
      bus.colour  <= BLACK;
      bus.plot    <= 1'b0;
      plot_last   <= 1'b0;
      snapshot    <= '0;
      req_pend    <= 1'b0;
      first_frame <= 1'b1;
`ifdef MODE_INDICATOR_EN
      mode_q      <= '0;
`endif
    end else begin
      bus.plot <= load;
      if (load) begin
        bus.x      <= sx;
        bus.y      <= sy;
        bus.colour <= colour_d;
        plot_last  <= slast;
      end
      if (go) begin
        snapshot    <= bus.keys;
        first_frame <= 1'b0;
        req_pend    <= 1'b0;
`ifdef MODE_INDICATOR_EN
        mode_q      <= bus.mode;
`endif
      end else if (bus.redraw_req) begin
        req_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_display_renderer.sv
// Bench for key_display_renderer: a frame-level reference model queues the
// whole expected pixel stream when it decides a frame starts; a monitor on
// the falling edge pops one entry per cycle and compares.
module tb_key_display_renderer;
  import gui_pkg::*;

  localparam int NUM_KEYS = 4;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int KEY_W    = SCREEN_W / NUM_KEYS;
  localparam int NPIX     = SCREEN_W * SCREEN_H;
`ifdef MODE_INDICATOR_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  localparam int EV_PIX  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_RST  = 2;

  typedef struct {
    int kind;
    int x;
    int y;
    int c;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  key_display_renderer_if #(.NUM_KEYS(NUM_KEYS)) bus ();

  key_display_renderer #(
    .NUM_KEYS (NUM_KEYS),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  n_done_seen = 0;

  int  m_left = 0;
  bit  m_done = 1'b0;
  bit  m_first = 1'b1;
  bit  m_pend = 1'b0;
  int  m_snap = 0;
  int  m_mode = 0;
  int  m_frames = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: actual=%08h required=%08h at t=%0t", name, got, exp, $time);
  endtask

  function automatic int exp_colour(input int x, input int y, input int snap, input int mode);
    int k;
    int off;
    int c;
    k   = x / KEY_W;
    off = x % KEY_W;
    if (off == KEY_W - 1 && k < NUM_KEYS - 1) c = 0;
    else if (((snap >> k) & 1) == 1)          c = 1;
    else                                      c = 7;
    if (IND_EN && x < 4 && y < 4) begin
      if (mode == 1)      c = 4;
      else if (mode == 2) c = 2;
    end
    return c;
  endfunction

  task automatic push_frame(input int snap, input int mode);
    for (int yy = 0; yy < SCREEN_H; yy++)
      for (int xx = 0; xx < SCREEN_W; xx++)
        sb.push_back('{EV_PIX, xx, yy, exp_colour(xx, yy, snap, mode)});
    sb.push_back('{EV_DONE, 0, 0, 0});
  endtask

  // Reference model: decides frame starts from the observed inputs.
  initial begin
    forever begin
      @(posedge clock);
      if (!reset) begin
        sb.delete();
        sb.push_back('{EV_RST, 0, 0, 0});
        m_left  = 0;
        m_done  = 1'b0;
        m_first = 1'b1;
        m_pend  = 1'b0;
        m_snap  = 0;
        m_mode  = 0;
      end else if (m_left > 0) begin
        if (bus.redraw_req) m_pend = 1'b1;
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (m_done) begin
        if (bus.redraw_req) m_pend = 1'b1;
        m_done = 1'b0;
      end else if (bus.redraw_req || m_pend || m_first || int'(bus.keys) != m_snap) begin
        m_snap  = int'(bus.keys);
        m_mode  = int'(bus.mode);
        m_pend  = 1'b0;
        m_first = 1'b0;
        m_left  = NPIX;
        m_frames++;
        push_frame(m_snap, m_mode);
      end
    end
  end

  // Monitor: every queued entry is due on the very next falling edge.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.kind == EV_RST) begin
          check("reset_outputs",
                int'({bus.plot, bus.busy, bus.frame_done, bus.x, bus.y, bus.colour}), 0);
        end else if (e.kind == EV_PIX) begin
          check($sformatf("pixel(%0d,%0d) plot/busy/done/x/y/colour", e.x, e.y),
                int'({bus.plot, bus.busy, bus.frame_done, bus.x, bus.y, bus.colour}),
                int'({3'b110, 8'(e.x), 7'(e.y), 3'(e.c)}));
        end else begin
          if (bus.frame_done) n_done_seen++;
          check("frame_done plot/busy/done",
                int'({bus.plot, bus.busy, bus.frame_done}), int'(3'b001));
        end
      end else begin
        check("idle plot/busy/done", int'({bus.plot, bus.busy, bus.frame_done}), 0);
      end
    end
  end

  task automatic wait_pixel(input int frame, input int k);
    int t;
    t = 0;
    while (!(m_frames == frame && m_left > 0 && NPIX - m_left >= k) && t < 60000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 60000) begin
      n_checks++;
      $display("FAIL wait_pixel frame %0d pixel %0d: not reached in 60000 cycles", frame, k);
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((m_left > 0 || m_done || sb.size() > 0 || bus.busy) && t < budget) begin
      @(negedge clock);
      t++;
    end
    if (t >= budget) begin
      n_checks++;
      $display("FAIL wait_idle: renderer still busy after %0d cycles", budget);
    end
  endtask

  task automatic pulse_req();
    bus.redraw_req = 1'b1;
    @(negedge clock);
    bus.redraw_req = 1'b0;
  endtask

  initial begin
    bus.keys       = '0;
    bus.redraw_req = 1'b0;
    bus.mode       = 2'b00;
    reset          = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Frame 1: unconditional after release; two requests make one extra frame.
    wait_pixel(1, 2000);
    pulse_req();
    bus.mode = 2'($urandom_range(0, 3));
    wait_pixel(1, 3000);
    pulse_req();

    // Frame 2: from the pending request; key change mid-frame is deferred.
    wait_pixel(2, 5000);
    bus.keys = 4'b0010;

    // Frame 3: keys 0010; aborted by reset at pixel 1000.
    wait_pixel(3, 1000);
    reset    = 1'b0;
    bus.keys = 4'($urandom_range(1, 15));
    bus.mode = 2'b01;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Frame 4: full frame after release; mode changes mid-frame are ignored.
    wait_pixel(4, 100);
    bus.mode = 2'($urandom_range(0, 3));
    wait_idle(30000);

    // Mode changes alone must not start a frame.
    for (int i = 0; i < 50; i++) begin
      bus.mode = 2'($urandom_range(0, 3));
      @(negedge clock);
    end
    repeat (4) @(negedge clock);

    check("frame_done_pulses", n_done_seen, 3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_display_renderer.md
KEY_DISPLAY_RENDERER -- requirements
Module: key_display_renderer

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, number of on-screen keys (2..8).
REQ-002 The block SHALL have parameter SCREEN_W, default 160, frame width in pixels (multiple of NUM_KEYS, ≤256).
REQ-003 The block SHALL have parameter SCREEN_H, default 120, frame height in pixels (≤128).
REQ-004 The block SHALL have port clock  input  1  clock, all logic on posedge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port keys  input  NUM_KEYS  key pressed levels, bit i = key i.
REQ-007 The block SHALL have port redraw_req  input  1  one-cycle request for a full frame.
REQ-008 The block SHALL have port mode  input  2  00 idle, 01 recording, 10 playback, 11 treated as 00.
REQ-009 The block SHALL have port x  output  8  registered pixel column.
REQ-010 The block SHALL have port y  output  7  registered pixel row.
REQ-011 The block SHALL have port colour  output  3  registered pixel colour, RGB.
REQ-012 The block SHALL have port plot  output  1  high when x/y/colour is a valid pixel write.
REQ-013 The block SHALL have port busy  output  1  high while a frame is being drawn.
REQ-014 The block SHALL have port frame_done  output  1  single-cycle pulse after the last pixel of a frame.

Function
REQ-015 The FSM SHALL have states IDLE, DRAW, DONE; DONE lasts exactly one cycle and then goes to IDLE.
REQ-016 IDLE->DRAW SHALL occur when redraw_req=1, or keys != drawn snapshot, or the first cycle after reset release.
REQ-017 On IDLE->DRAW, keys SHALL be latched into the snapshot; key changes during DRAW SHALL NOT alter the current frame.
REQ-018 DRAW SHALL emit one pixel per cycle, x fastest (0..SCREEN_W-1), then y (0..SCREEN_H-1): exactly SCREEN_W*SCREEN_H plot cycles, no gaps.
REQ-019 First pixel (0,0) SHALL appear with plot=1 in the first cycle after the IDLE->DRAW transition.
REQ-020 KEY_W SHALL equal SCREEN_W/NUM_KEYS; key index and in-key offset SHALL be tracked by counters, with no divider or modulo hardware.
REQ-021 Colour priority SHALL be: divider (offset = KEY_W-1 and key index < NUM_KEYS-1) -> BLACK 000; else snapshot bit set -> BLUE 001; else WHITE 111.
REQ-022 busy SHALL equal 1 exactly in DRAW; frame_done SHALL be 1 exactly in DONE; plot SHALL be 0 outside DRAW.
REQ-023 A redraw_req during DRAW or DONE SHALL be held pending and start a new frame from the next IDLE cycle.
REQ-024 Keys differing from the snapshot at DONE SHALL start a new frame one cycle later, from IDLE.
REQ-025 Counters SHALL wrap to 0 at frame end; x and y SHALL hold their last values in IDLE.

Reset
REQ-026 While reset=0: state IDLE, x=0, y=0, colour=000, plot=0, busy=0, frame_done=0, snapshot=0, pending request cleared.
REQ-027 A reset asserted mid-frame SHALL abort the frame immediately, with no further plot.
REQ-028 After release, exactly one full frame SHALL be drawn unconditionally (REQ-016).

Configuration
REQ-029 Macro MODE_INDICATOR_EN, when defined, SHALL override the colour of pixels with x<4 and y<4: RED 100 for mode 01, GREEN 010 for mode 10; mode is sampled at IDLE->DRAW.
REQ-030 When MODE_INDICATOR_EN is undefined, mode SHALL be ignored; it is unconnected internally and colours follow REQ-021 only.
REQ-031 A mode change SHALL NOT by itself trigger a redraw; mode is sampled only when a frame starts.

Structure
REQ-032 Shared package gui_pkg SHALL hold the colour constants (BLACK, BLUE, GREEN, RED, WHITE) and the mode encodings.
REQ-033 Sub-module pixel_scanner SHALL contain the x/y/key-index/offset counters with start, advance, and last_pixel signals; the FSM and colour logic stay in the top level.

Verification
REQ-034 Reset release, keys=0 (defaults) -> 19200 consecutive plot cycles; all pixels WHITE except x=39,79,119 BLACK; one frame_done pulse; then IDLE.
REQ-035 keys=4'b0010 in IDLE -> new frame: x 40..78 BLUE, x=79 BLACK, others per REQ-021.
REQ-036 keys toggles 0001->0000 at pixel 5000 -> current frame keeps x 0..38 BLUE; second frame starts the cycle after DONE and is all-WHITE keys.
REQ-037 redraw_req pulsed during DRAW -> exactly one extra frame after DONE; second pulse in the same frame is not counted twice.
REQ-038 Reset low at pixel 1000 -> plot=0 the next cycle, all outputs 0; full frame after release.
REQ-039 MODE_INDICATOR_EN defined, mode=01 -> pixels (0..3,0..3) RED; undefined -> those pixels WHITE or BLUE.
